// File: rtl/ys_poly_small_seq3.sv
// ys_poly_small mode-3 sequencer: streams RAM1 words, writes 3*(g[i-1]-g[i]) to RAM2.
// Optional stall input enabled by defining YS_POLY_SMALL_SEQ3_STALL_EN.
module ys_poly_small_seq3 #(
    parameter int NTRU_N = 701,
    parameter int DW     = 13,
    parameter int WORDS  = (NTRU_N + 1) / 2,
    parameter int AW     = 9
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
`ifdef YS_POLY_SMALL_SEQ3_STALL_EN
    input  logic            stall,
`endif
    output logic            busy,
    output logic            done,
    output logic            ram1_ena,
    output logic [AW-1:0]   ram1_addra,
    input  logic [2*DW-1:0] ram1_douta,
    output logic            ram2_wea,
    output logic [AW-1:0]   ram2_addra,
    output logic [2*DW-1:0] ram2_dina
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    localparam logic [AW-1:0] LAST = AW'(WORDS - 1);
    localparam bit            ODD  = (NTRU_N % 2) == 1;

    state_t            r_state;
    state_t            w_next;
    logic [AW-1:0]     r_addr;
    logic              r_drain;
    logic              r_v1;
    logic [AW-1:0]     r_a1;
    logic              r_wea;
    logic [AW-1:0]     r_waddr;
    logic [2*DW-1:0]   r_wdata;
    logic [DW-1:0]     r_prev;

    logic              w_adv;
    logic [2*DW-1:0]   w_word;
    logic [DW-1:0]     w_g0;
    logic [DW-1:0]     w_g1;
    logic [DW-1:0]     w_d0;
    logic [DW-1:0]     w_d1;
    logic [DW-1:0]     w_m0;
    logic [DW-1:0]     w_m1;
    logic              w_pad;

`ifdef YS_POLY_SMALL_SEQ3_STALL_EN
    logic              r_hold_v;
    logic [2*DW-1:0]   r_dhold;

    assign w_adv = !stall;

    // The RAM keeps reading during a stall, so park the stage-1 word here.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hold_v <= 1'b0;
            r_dhold  <= '0;
        end else if (stall) begin
            if (!r_hold_v) begin
                r_hold_v <= 1'b1;
                r_dhold  <= ram1_douta;
            end
        end else begin
            r_hold_v <= 1'b0;
        end
    end

    assign w_word = r_hold_v ? r_dhold : ram1_douta;
`else
    assign w_adv  = 1'b1;
    assign w_word = ram1_douta;
`endif

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:  if (start) w_next = S_RUN;
            S_RUN:   if (r_addr == LAST) w_next = S_DRAIN;
            S_DRAIN: if (r_drain) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    assign w_g0  = w_word[DW-1:0];
    assign w_g1  = w_word[2*DW-1:DW];
    assign w_d0  = (r_a1 == '0) ? (DW'(0) - w_g0) : (r_prev - w_g0);
    assign w_d1  = w_g0 - w_g1;
    assign w_m0  = {w_d0[DW-2:0], 1'b0} + w_d0;
    assign w_m1  = {w_d1[DW-2:0], 1'b0} + w_d1;
    assign w_pad = ODD && (r_a1 == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_addr  <= '0;
            r_drain <= 1'b0;
            r_v1    <= 1'b0;
            r_a1    <= '0;
            r_wea   <= 1'b0;
            r_waddr <= '0;
            r_wdata <= '0;
            r_prev  <= '0;
        end else if (w_adv) begin
            r_state <= w_next;
            r_drain <= (r_state == S_DRAIN) && !r_drain;
            if ((r_state == S_RUN) && (w_next == S_RUN))
                r_addr <= r_addr + 1'b1;
            else
                r_addr <= '0;
            r_v1  <= (r_state == S_RUN);
            r_a1  <= r_addr;
            r_wea <= r_v1;
            if (r_v1) begin
                r_waddr <= r_a1;
                r_wdata <= {(w_pad ? DW'(0) : w_m1), w_m0};
                r_prev  <= w_g1;
            end
        end
    end

    assign busy       = (r_state == S_RUN) || (r_state == S_DRAIN);
    assign done       = (r_state == S_DONE) && w_adv;
    assign ram1_ena   = (r_state == S_RUN);
    assign ram1_addra = r_addr;
    assign ram2_wea   = r_wea && w_adv;
    assign ram2_addra = r_waddr;
    assign ram2_dina  = r_wdata;

endmodule

// File: tb/tb_ys_poly_small_seq3.sv
// Bench for ys_poly_small_seq3: N=5 table vectors plus N=701 random runs.
// Stall scenario compiled in when YS_POLY_SMALL_SEQ3_STALL_EN is defined.
module tb_ys_poly_small_seq3;

    localparam int DW = 13;
    localparam int AW = 9;
    localparam int NA = 5;
    localparam int WA = 3;
    localparam int NB = 701;
    localparam int WB = 351;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic            a_start, a_busy, a_done, a_ena, a_wea;
    logic [AW-1:0]   a_raddr, a_waddr;
    logic [2*DW-1:0] a_dout, a_din;
    logic            b_start, b_busy, b_done, b_ena, b_wea;
    logic [AW-1:0]   b_raddr, b_waddr;
    logic [2*DW-1:0] b_dout, b_din;
`ifdef YS_POLY_SMALL_SEQ3_STALL_EN
    logic            a_stall = 1'b0;
    logic            b_stall = 1'b0;
`endif

    ys_poly_small_seq3 #(.NTRU_N(NA), .DW(DW), .AW(AW)) u_a (
        .clk(clk), .rst(rst), .start(a_start),
`ifdef YS_POLY_SMALL_SEQ3_STALL_EN
        .stall(a_stall),
`endif
        .busy(a_busy), .done(a_done),
        .ram1_ena(a_ena), .ram1_addra(a_raddr), .ram1_douta(a_dout),
        .ram2_wea(a_wea), .ram2_addra(a_waddr), .ram2_dina(a_din)
    );

    ys_poly_small_seq3 #(.NTRU_N(NB), .DW(DW), .AW(AW)) u_b (
        .clk(clk), .rst(rst), .start(b_start),
`ifdef YS_POLY_SMALL_SEQ3_STALL_EN
        .stall(b_stall),
`endif
        .busy(b_busy), .done(b_done),
        .ram1_ena(b_ena), .ram1_addra(b_raddr), .ram1_douta(b_dout),
        .ram2_wea(b_wea), .ram2_addra(b_waddr), .ram2_dina(b_din)
    );

    typedef struct {
        logic [AW-1:0]   addr;
        logic [2*DW-1:0] data;
    } wr_t;

    typedef struct {
        logic [DW-1:0] g [NA];
        logic [DW-1:0] e [NA+1];
    } vec_t;

    wr_t             q_a[$];
    wr_t             q_b[$];
    vec_t            tbl[5];
    logic [2*DW-1:0] mem_a[0:511];
    logic [2*DW-1:0] mem_b[0:511];
    logic [DW-1:0]   gb[0:NB];
    int wr_a, wr_b, dn_a, dn_b;
    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    always @(posedge clk) begin
        if (a_ena) a_dout <= mem_a[a_raddr];
        if (b_ena) b_dout <= mem_b[b_raddr];
    end

    always @(negedge clk) begin
        wr_t e;
        if (a_done) dn_a++;
        if (b_done) dn_b++;
        if (a_wea) begin
            wr_a++;
            if (q_a.size() == 0) chk("a_extra_write", 1, 0);
            else begin
                e = q_a.pop_front();
                chk("a_waddr", a_waddr, e.addr);
                chk("a_wdata", a_din, e.data);
            end
        end
        if (b_wea) begin
            wr_b++;
            if (q_b.size() == 0) chk("b_extra_write", 1, 0);
            else begin
                e = q_b.pop_front();
                chk("b_waddr", b_waddr, e.addr);
                chk("b_wdata", b_din, e.data);
            end
        end
    end

    task automatic load_a(input int k);
        wr_t w;
        for (int i = 0; i < WA; i++) begin
            logic [DW-1:0] hi;
            hi = (2*i+1 < NA) ? tbl[k].g[2*i+1] : '0;
            mem_a[i] = {hi, tbl[k].g[2*i]};
            w.addr = AW'(i);
            w.data = {tbl[k].e[2*i+1], tbl[k].e[2*i]};
            q_a.push_back(w);
        end
    endtask

    task automatic load_b();
        wr_t w;
        logic [DW-1:0] e[0:NB];
        for (int i = 0; i < NB; i++) gb[i] = DW'($urandom_range(0, 8191));
        gb[NB] = '0;
        e[0] = DW'(-3 * int'(gb[0]));
        for (int i = 1; i < NB; i++) e[i] = DW'(3 * (int'(gb[i-1]) - int'(gb[i])));
        e[NB] = '0;
        for (int i = 0; i < WB; i++) begin
            mem_b[i] = {gb[2*i+1], gb[2*i]};
            w.addr = AW'(i);
            w.data = {e[2*i+1], e[2*i]};
            q_b.push_back(w);
        end
    endtask

    task automatic pulse_a();
        @(negedge clk) a_start = 1'b1;
        @(posedge clk);
        #1 a_start = 1'b0;
    endtask

    task automatic pulse_b();
        @(negedge clk) b_start = 1'b1;
        @(posedge clk);
        #1 b_start = 1'b0;
    endtask

    task automatic wait_a(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!a_done && n < 3000);
    endtask

    task automatic wait_b(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!b_done && n < 3000);
    endtask

    initial begin
        int n;
        tbl[0].g = '{1, 2, 3, 4, 5};
        tbl[0].e = '{8189, 8189, 8189, 8189, 8189, 0};
        tbl[1].g = '{4095, 0, 0, 0, 0};
        tbl[1].e = '{4099, 4093, 0, 0, 0, 0};
        tbl[2].g = '{0, 0, 0, 0, 0};
        tbl[2].e = '{0, 0, 0, 0, 0, 0};
        tbl[3].g = '{8191, 8191, 8191, 8191, 8191};
        tbl[3].e = '{3, 0, 0, 0, 0, 0};
        tbl[4].g = '{0, 1, 0, 1, 0};
        tbl[4].e = '{0, 8189, 3, 8189, 3, 0};
        a_start = 1'b0;
        b_start = 1'b0;
        wr_a = 0; wr_b = 0; dn_a = 0; dn_b = 0;

        repeat (3) @(negedge clk);
        chk("reset_outputs_a", {a_busy, a_done, a_ena, a_raddr, a_wea, a_waddr, a_din}, 0);
        chk("reset_outputs_b", {b_busy, b_done, b_ena, b_raddr, b_wea, b_waddr, b_din}, 0);
        rst = 1'b0;

        for (int k = 0; k < 5; k++) begin
            wr_a = 0; dn_a = 0;
            load_a(k);
            pulse_a();
            chk("a_busy_after_start", a_busy, 1);
            wait_a(n);
            chk("a_done_latency", n, WA + 3);
            chk("a_busy_at_done", a_busy, 0);
            @(negedge clk);
            chk("a_done_width", a_done, 0);
            chk("a_write_count", wr_a, WA);
            chk("a_done_count", dn_a, 1);
        end

        wr_a = 0; dn_a = 0;
        load_a(0);
        pulse_a();
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("abort_outputs", {a_busy, a_done, a_ena, a_raddr, a_wea, a_waddr, a_din}, 0);
        q_a.delete();
        rst = 1'b0;
        repeat (10) @(negedge clk);
        chk("abort_no_done", dn_a, 0);
        chk("abort_no_write", wr_a, 0);

        wr_a = 0; dn_a = 0;
        load_a(1);
        pulse_a();
        wait_a(n);
        chk("a_rerun_latency", n, WA + 3);
        @(negedge clk);
        chk("a_rerun_writes", wr_a, WA);

        wr_b = 0; dn_b = 0;
        load_b();
        pulse_b();
        wait_b(n);
        chk("b_done_latency", n, WB + 3);
        @(negedge clk);
        chk("b_write_count", wr_b, WB);
        chk("b_done_count", dn_b, 1);

        wr_b = 0; dn_b = 0;
        load_b();
        pulse_b();
        repeat (20) @(negedge clk);
        pulse_b();
        wait_b(n);
        chk("restart_latency", n, WB + 3 - 21);
        repeat (10) @(negedge clk);
        chk("restart_writes", wr_b, WB);
        chk("restart_done_count", dn_b, 1);

`ifdef YS_POLY_SMALL_SEQ3_STALL_EN
        wr_b = 0; dn_b = 0;
        load_b();
        pulse_b();
        fork
            wait_b(n);
            begin
                repeat (100) @(posedge clk);
                #1 b_stall = 1'b1;
                repeat (4) @(posedge clk);
                #1 b_stall = 1'b0;
            end
        join
        chk("stall_latency", n, WB + 3 + 4);
        @(negedge clk);
        chk("stall_writes", wr_b, WB);
        chk("stall_done_count", dn_b, 1);
`endif

        chk("a_queue_empty", q_a.size(), 0);
        chk("b_queue_empty", q_b.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
